mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 186 ++++++++++++++++++
 tb/tb_mdu_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: shift-add MUL, restoring DIV/DIVU/REM,
// one operation in flight, valid/ready on both sides, kill flushes it.
// Ports: clk, rst_n (sync, active low), in_valid/in_ready, op, src_a,
//        src_b, kill, out_valid/out_ready, result.
package rv32i_pkg;
    parameter int XLEN = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_DIVU = 2'b10,
        OP_REM  = 2'b11
    } mdu_op_e;
endpackage

module mdu_seq #(
    parameter int XLEN = rv32i_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    import rv32i_pkg::*;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e          state_q, state_d;
    mdu_op_e         op_q, op_d;
    // MUL: a = multiplicand, b = multiplier, acc = product.
    // DIV: a = dividend shifting into quotient, b = divisor, acc = remainder.
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;

    mdu_op_e         req_op;
    logic            req_sgn;
    logic            req_div0;
    logic            req_ovf;
    logic            a_neg;
    logic            b_neg;

    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] step_a;
    logic [XLEN-1:0] step_b;
    logic [XLEN-1:0] step_acc;

    assign req_op   = mdu_op_e'(op);
    assign req_sgn  = (req_op == OP_DIV) || (req_op == OP_REM);
    assign req_div0 = (req_op != OP_MUL) && (src_b == '0);
    assign req_ovf  = req_sgn && (src_a == MIN_NEG) && (src_b == '1);
    assign a_neg    = req_sgn && src_a[XLEN-1];
    assign b_neg    = req_sgn && src_b[XLEN-1];

    // Restoring step: shift next dividend bit into the partial remainder
    // and subtract the divisor; a borrow means keep the old value.
    assign trial = {acc_q, a_q[XLEN-1]};
    assign diff  = trial - {1'b0, b_q};

    always_comb begin
        step_a   = a_q;
        step_b   = b_q;
        step_acc = acc_q;
        if (op_q == OP_MUL) begin
            step_acc = acc_q + (b_q[0] ? a_q : '0);
            step_a   = a_q << 1;
            step_b   = b_q >> 1;
        end else if (!diff[XLEN]) begin
            step_acc = diff[XLEN-1:0];
            step_a   = {a_q[XLEN-2:0], 1'b1};
        end else begin
            step_acc = trial[XLEN-1:0];
            step_a   = {a_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = req_op;
                    cnt_d = CNT_INIT;
                    acc_d = '0;
                    neg_d = 1'b0;
                    res_d = '0;
                    a_d   = src_a;
                    b_d   = src_b;
                    if (req_div0) begin
                        res_d   = (req_op == OP_REM) ? src_a : '1;
                        state_d = DONE;
                    end else if (req_ovf) begin
                        res_d   = (req_op == OP_DIV) ? src_a : '0;
                        state_d = DONE;
                    end else begin
                        // Divide on magnitudes; sign restored at the end.
                        a_d     = a_neg ? (~src_a + 1'b1) : src_a;
                        b_d     = b_neg ? (~src_b + 1'b1) : src_b;
                        neg_d   = (req_op == OP_REM) ? a_neg
                                                     : (a_neg ^ b_neg);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    a_d   = step_a;
                    b_d   = step_b;
                    acc_d = step_acc;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        unique case (op_q)
                            OP_MUL:  res_d = step_acc;
                            OP_REM:  res_d = neg_q ? (~step_acc + 1'b1)
                                                   : step_acc;
                            default: res_d = neg_q ? (~step_a + 1'b1)
                                                   : step_a;
                        endcase
                    end
                end
            end
            DONE: begin
                if (kill || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = out_valid ? res_q : '0;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus random
// operations scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mdu_seq;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    mdu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
        case (o)
            2'd0: return a * b;
            2'd1: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            2'd2: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            default: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return sa % sb;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (o == 2'd0) return 33;
        if (b == 0) return 1;
        if (o != 2'd2 && a == MINV && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Present a request at a negedge with in_ready high; returns after
    // the accept edge with inputs scrambled.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 2'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    // Count edges from the accept edge until out_valid is seen high.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        bit bad;
        lat = 1;
        bad = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (result !== 32'd0 || in_ready !== 1'b0) bad = 1;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " idle outputs while busy"}, 32'(bad), 32'd0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " out_valid after consume"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after consume"}, 32'(in_ready), 32'd1);
        chk({tag, " result zero after"}, result, 32'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er,
                         input int el, input string tag);
        issue(o, a, b, tag);
        wait_valid(tag, el);
        chk({tag, " result"}, result, er);
        consume(tag);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] held;
        bit          bad;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'd0;
        src_a     = '0;
        src_b     = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);

        do_op(2'd0, 32'd7, 32'd6, 32'd42, 33, "mul 7*6");
        do_op(2'd1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33, "div -7/2");
        do_op(2'd3, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33, "rem -7,2");
        do_op(2'd2, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, "divu");
        do_op(2'd1, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, "div x/0");
        do_op(2'd3, 32'd5, 32'd0, 32'd5, 1, "rem 5,0");
        do_op(2'd2, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "divu x/0");
        do_op(2'd1, MINV, 32'hFFFF_FFFF, MINV, 1, "div ovf");
        do_op(2'd3, MINV, 32'hFFFF_FFFF, 32'd0, 1, "rem ovf");
        do_op(2'd0, 32'd0, 32'd1234, 32'd0, 33, "mul zero");

        // Back-pressure: result must stay put and new requests ignored.
        issue(2'd0, 32'd1000, 32'd77, "stall");
        wait_valid("stall", 33);
        held = result;
        chk("stall result", held, 32'd77000);
        bad = 0;
        in_valid = 1'b1;
        op       = 2'd2;
        src_a    = 32'd50;
        src_b    = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 32'd77000 ||
                in_ready !== 1'b0) bad = 1;
        end
        chk("stall stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("stall no accept on consume", 32'(in_ready), 32'd1);
        chk("stall out_valid low", 32'(out_valid), 32'd0);

        // Kill in the fifth busy cycle.
        issue(2'd0, 32'd11, 32'd13, "kill busy");
        repeat (4) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill busy in_ready", 32'(in_ready), 32'd1);
        chk("kill busy out_valid", 32'(out_valid), 32'd0);
        do_op(2'd0, 32'd3, 32'd3, 32'd9, 33, "mul 3*3 a");

        // Kill in DONE wins over out_ready.
        issue(2'd2, 32'd40, 32'd3, "kill done");
        wait_valid("kill done", 33);
        kill      = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        kill      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("kill done in_ready", 32'(in_ready), 32'd1);
        chk("kill done out_valid", 32'(out_valid), 32'd0);
        do_op(2'd0, 32'd3, 32'd3, 32'd9, 33, "mul 3*3 b");

        // Kill while idle does not block the concurrent request.
        kill = 1'b1;
        issue(2'd0, 32'd5, 32'd5, "kill idle");
        kill = 1'b0;
        wait_valid("kill idle", 33);
        chk("kill idle result", result, 32'd25);
        consume("kill idle");

        // Reset in busy cycle 20 drops the operation.
        issue(2'd1, 32'd1000, 32'd3, "reset busy");
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
        end
        chk("reset busy quiet", 32'(bad), 32'd0);
        do_op(2'd2, 32'd100, 32'd7, 32'd14, 33, "divu 100/7");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = rnd_operand();
            rb = rnd_operand();
            do_op(ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb),
                  $sformatf("rand%0d op%0d", i, ro));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
